extend_pipe: RTL and testbench

EXTEND_PIPE -- requirements
Module: extend_pipe

---
 rtl/extend_pipe_if.sv | 28 ++
 rtl/extend_pipe.sv | 122 ++++++++++++
 tb/tb_extend_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/extend_pipe_if.sv
// rtl/extend_pipe_if.sv - handshake bundle for the immediate extension pipe
interface extend_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       Immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Immop;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    // Pipe side: consumes instructions, produces immediates
    modport slave (
        input  in_valid, instr, Immsrc, in_tag, out_ready,
        output in_ready, out_valid, Immop, out_tag, out_err
    );

    // Producer/consumer side surrounding the pipe
    modport master (
        output in_valid, instr, Immsrc, in_tag, out_ready,
        input  in_ready, out_valid, Immop, out_tag, out_err
    );
endinterface

// File: rtl/extend_pipe.sv
// rtl/extend_pipe.sv - RV32 immediate decode/extend behind a 2-entry skid buffer
module extend_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    extend_pipe_if.slave     bus,
    output logic [ERR_W-1:0] err_cnt
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              in_ready_q;
    logic              in_xfer;
    logic              out_xfer;

    logic [WIDTH-1:0]  main_imm;
    logic [TAG_W-1:0]  main_tag;
    logic              main_err;
    logic [WIDTH-1:0]  skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_err;

    logic signed [31:0] raw;
    logic [WIDTH-1:0]   dec_imm;
    logic               dec_err;

    wire [31:0] i = bus.instr;

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = (state != S_EMPTY) && bus.out_ready;

    // Decode to a 32-bit value whose bit 31 is the correct fill bit; zero-extended
    // formats leave bit 31 clear, so a single sign extension to WIDTH covers all cases
    always_comb begin
        raw     = '0;
        dec_err = 1'b0;
        case (bus.Immsrc)
            3'b000:  raw = {{20{i[31]}}, i[31:20]};
            3'b001:  raw = {{20{i[31]}}, i[31:25], i[11:7]};
            3'b010:  raw = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'b011:  raw = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'b100:  raw = {i[31:12], 12'b0};
            3'b101:  raw = {27'b0, i[24:20]};
            3'b110:  raw = {27'b0, i[19:15]};
            default: dec_err = 1'b1;
        endcase
        dec_imm = WIDTH'(raw);
    end

    // Buffer occupancy transitions; FULL never sees an in-transfer since in_ready is low
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (in_xfer) state_nxt = S_ONE;
            S_ONE: begin
                if (in_xfer && !out_xfer)      state_nxt = S_FULL;
                else if (!in_xfer && out_xfer) state_nxt = S_EMPTY;
            end
            S_FULL:  if (out_xfer) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
        endcase
    end

    // State and registered in_ready, so upstream never sees a path from out_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_FULL);
        end
    end

    // Head register loads new data when it is free or draining, else takes the skid entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_imm <= '0;
            main_tag <= '0;
            main_err <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            if ((state == S_EMPTY && in_xfer) || (state == S_ONE && in_xfer && out_xfer)) begin
                main_imm <= dec_imm;
                main_tag <= bus.in_tag;
                main_err <= dec_err;
            end else if (state == S_FULL && out_xfer) begin
                main_imm <= skid_imm;
                main_tag <= skid_tag;
                main_err <= skid_err;
            end
            if (state == S_ONE && in_xfer && !out_xfer) begin
                skid_imm <= dec_imm;
                skid_tag <= bus.in_tag;
                skid_err <= dec_err;
            end
        end
    end

    // Saturating count of accepted illegal selects
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (in_xfer && dec_err && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state != S_EMPTY);
    assign bus.Immop     = main_imm;
    assign bus.out_tag   = main_tag;
    assign bus.out_err   = main_err;
endmodule

// File: tb/tb_extend_pipe.sv
// tb/tb_extend_pipe.sv - randomized and directed checks of extend_pipe against a queue model
module tb_extend_pipe;
    localparam int WIDTH = 64;
    localparam int TAG_W = 5;
    localparam int ERR_W = 8;
    localparam int CNT_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [ERR_W-1:0] err_cnt;

    extend_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

    extend_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode by arithmetic on the field values
    function automatic logic [WIDTH-1:0] ref_imm(input logic [31:0] ins, input logic [2:0] s);
        longint sx;
        longint v;
        sx = longint'($signed(ins));
        case (s)
            3'd0: v = sx >>> 20;
            3'd1: v = (sx >>> 25) * 32 + longint'(ins[11:7]);
            3'd2: v = (sx >>> 31) * 4096 + longint'(ins[7]) * 2048
                      + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            3'd3: v = (sx >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                      + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            3'd4: v = (sx >>> 12) * 4096;
            3'd5: v = longint'(ins[24:20]);
            3'd6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        return v;
    endfunction

    // Model: FIFO of depth 2, pops then pushes on each edge
    initial begin
        forever begin
            bit m_in;
            bit m_out;
            ent_t e;
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                m_cnt = 0;
            end else begin
                m_in  = bus.in_valid && (q.size() < 2);
                m_out = (q.size() > 0) && bus.out_ready;
                if (m_out) void'(q.pop_front());
                if (m_in) begin
                    e.imm = ref_imm(bus.instr, bus.Immsrc);
                    e.tag = bus.in_tag;
                    e.err = (bus.Immsrc == 3'd7);
                    q.push_back(e);
                    if (e.err && m_cnt < CNT_MAX) m_cnt++;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
                chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
                chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
                if (q.size() != 0) begin
                    chk("Immop", bus.Immop, q[0].imm);
                    chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
                    chk("out_err", 64'(bus.out_err), 64'(q[0].err));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [2:0] s,
                          input logic [TAG_W-1:0] t);
        bus.in_valid = v;
        bus.instr    = ins;
        bus.Immsrc   = s;
        bus.in_tag   = t;
    endtask

    logic [31:0]      f_ins[3] = '{32'h80000863, 32'h12345037, 32'h01F01013};
    logic [2:0]       f_sel[3] = '{3'd2, 3'd4, 3'd5};
    logic [WIDTH-1:0] f_exp[3] = '{64'hFFFFFFFFFFFFF010, 64'h0000000012345000, 64'h1F};

    initial begin
        logic [TAG_W-1:0] got[$];
        bit acc;
        int n_out;
        int bad_ready;

        set_in(1'b0, 32'h0, 3'd0, '0);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst err_cnt", 64'(err_cnt), 64'd0);
        chk("rst Immop", bus.Immop, 64'd0);
        chk("rst out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst out_err", 64'(bus.out_err), 64'd0);
        rst_n = 1'b1;
        step();

        // single I-type, one cycle latency
        bus.out_ready = 1'b1;
        set_in(1'b1, 32'hFFF00093, 3'd0, 5'd7);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("itype valid", 64'(bus.out_valid), 64'd1);
        chk("itype Immop", bus.Immop, 64'hFFFFFFFFFFFFFFFF);
        chk("itype err", 64'(bus.out_err), 64'd0);
        chk("itype tag", 64'(bus.out_tag), 64'd7);
        step();

        // B, U, SHAMT formats
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, f_ins[k], f_sel[k], TAG_W'(k));
            step();
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk("format Immop", bus.Immop, f_exp[k]);
            step();
        end

        // backpressure: three back-to-back with out_ready low
        bus.out_ready = 1'b0;
        set_in(1'b1, $urandom, 3'd0, 5'd1);
        step();
        bus.in_tag = 5'd2;
        step();
        bus.in_tag = 5'd3;
        @(negedge clk);
        chk("bp in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp head", 64'(bus.out_tag), 64'd1);
        step();
        step();
        @(negedge clk);
        chk("bp hold tag", 64'(bus.out_tag), 64'd1);
        chk("bp hold ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) got.push_back(bus.out_tag);
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        chk("bp count", 64'(got.size()), 64'd3);
        for (int k = 0; k < got.size() && k < 3; k++)
            chk("bp order", 64'(got[k]), 64'(k + 1));
        step();

        // illegal select and counter saturation
        set_in(1'b1, $urandom, 3'd7, 5'd4);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("ill Immop", bus.Immop, 64'd0);
        chk("ill err", 64'(bus.out_err), 64'd1);
        chk("ill cnt", 64'(err_cnt), 64'd1);
        step();
        for (int k = 0; k < 300; k++) begin
            set_in(1'b1, $urandom, 3'd7, TAG_W'(k));
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("ill sat", 64'(err_cnt), 64'd255);

        // reset while FULL
        bus.out_ready = 1'b0;
        set_in(1'b1, $urandom, 3'd1, 5'd9);
        step();
        step();
        @(negedge clk);
        chk("mid full", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid err_cnt", 64'(err_cnt), 64'd0);
        step();

        // full-rate streaming
        bus.out_ready = 1'b1;
        step();
        step();
        n_out = 0;
        bad_ready = 0;
        for (int k = 0; k < 100; k++) begin
            set_in(1'b1, $urandom, 3'($urandom_range(0, 6)), TAG_W'(k));
            @(negedge clk);
            if (!bus.in_ready) bad_ready++;
            if (bus.out_valid) n_out++;
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        if (bus.out_valid) n_out++;
        step();
        chk("stream outputs", 64'(n_out), 64'd100);
        chk("stream stalls", 64'(bad_ready), 64'd0);

        // random traffic
        for (int k = 0; k < 2000; k++) begin
            set_in($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)),
                   TAG_W'($urandom));
            bus.out_ready = $urandom_range(0, 9) < 6;
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        @(negedge clk);
        chk("drain empty", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
